// File: rtl/jpeg_bitstream_packer_if.sv
// Signal bundle between the entropy coder side (master) and the bitstream packer (slave),
// including the output RAM write port and frame status.
interface jpeg_bitstream_packer_if #(
  parameter int ADDR_W = 24
);
  logic [31:0]       bits;
  logic              rdy;
  logic [4:0]        eof_cnt;
  logic              eof_p;
  logic              almost_full;
  logic [7:0]        ram_byte;
  logic              ram_wren;
  logic [ADDR_W-1:0] ram_wraddr;
  logic [ADDR_W-1:0] frame_size;
  logic              done;
  logic              overflow;

  modport master (
    output bits, rdy, eof_cnt, eof_p, almost_full,
    input  ram_byte, ram_wren, ram_wraddr, frame_size, done, overflow
  );

  modport slave (
    input  bits, rdy, eof_cnt, eof_p, almost_full,
    output ram_byte, ram_wren, ram_wraddr, frame_size, done, overflow
  );
endinterface

// File: rtl/jpeg_bitstream_packer.sv
// Buffers 32-bit entropy-coded words, serialises them MSB-first into bytes with 0xFF00 stuffing,
// pads the final byte with 1s, appends the EOI marker and writes the bytes to the output RAM.
module jpeg_bitstream_packer #(
  parameter int FIFO_DEPTH = 8,
  parameter int ADDR_W     = 24,
  parameter int ADD_EOI    = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  jpeg_bitstream_packer_if.slave  bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {IDLE, LOAD, EMIT, STUFF, EOI_FF, EOI_D9, DONE} state_t;

  typedef struct packed {
    logic        last;
    logic [5:0]  nbits;
    logic [31:0] word;
  } entry_t;

  localparam state_t END_ST = (ADD_EOI != 0) ? EOI_FF : DONE;

  state_t            state_q, state_d;
  entry_t            mem_q [FIFO_DEPTH];
  entry_t            mem_d [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [31:0]       shift_q, shift_d;
  logic [2:0]        bytes_q, bytes_d;
  logic              last_q, last_d;
  logic [7:0]        ram_byte_q, ram_byte_d;
  logic              ram_wren_q, ram_wren_d;
  logic [ADDR_W-1:0] addr_q, addr_d, wraddr_q, wraddr_d, frame_size_q, frame_size_d;
  logic              done_q, done_d, overflow_q, overflow_d;

  logic              stall, fifo_empty, pop, push_a, push_b;
  logic [CW-1:0]     avail;
  entry_t            head;
  logic [2:0]        head_bytes, bytes_left;
  state_t            after_data;

  // The sink stall freezes every state that could emit or consume; DONE only waits for a new frame.
  assign stall      = bus.almost_full && (state_q != DONE);
  assign fifo_empty = (count_q == '0);
  assign head       = mem_q[rd_ptr_q];
  assign head_bytes = head.nbits[5:3] + {2'b00, |head.nbits[2:0]};
  assign pop        = (state_q == LOAD) && !stall;
  assign avail      = CW'(FIFO_DEPTH) - count_q + CW'(pop);
  assign push_a     = bus.rdy && (avail != '0);
  assign push_b     = bus.eof_p && (avail >= (push_a ? CW'(2) : CW'(1)));
  assign bytes_left = (state_q == EMIT) ? bytes_q - 3'd1 : bytes_q;

  always_comb begin
    if (last_q)           after_data = END_ST;
    else if (!fifo_empty) after_data = LOAD;
    else                  after_data = IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      shift_q      <= '0;
      bytes_q      <= '0;
      last_q       <= 1'b0;
      ram_byte_q   <= '0;
      ram_wren_q   <= 1'b0;
      addr_q       <= '0;
      wraddr_q     <= '0;
      frame_size_q <= '0;
      done_q       <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      mem_q        <= mem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      shift_q      <= shift_d;
      bytes_q      <= bytes_d;
      last_q       <= last_d;
      ram_byte_q   <= ram_byte_d;
      ram_wren_q   <= ram_wren_d;
      addr_q       <= addr_d;
      wraddr_q     <= wraddr_d;
      frame_size_q <= frame_size_d;
      done_q       <= done_d;
      overflow_q   <= overflow_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (!stall) begin
      case (state_q)
        IDLE:   if (!fifo_empty) state_d = LOAD;
        LOAD: begin
          if (head_bytes != 3'd0) state_d = EMIT;
          else if (head.last)     state_d = END_ST;
          else                    state_d = IDLE;
        end
        EMIT: begin
          if (shift_q[31:24] == 8'hFF) state_d = STUFF;
          else if (bytes_left != 3'd0) state_d = EMIT;
          else                         state_d = after_data;
        end
        STUFF:  state_d = (bytes_left != 3'd0) ? EMIT : after_data;
        EOI_FF: state_d = EOI_D9;
        EOI_D9: state_d = DONE;
        DONE:   if (bus.rdy || bus.eof_p || !fifo_empty) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    mem_d        = mem_q;
    wr_ptr_d     = wr_ptr_q + AW'(push_a) + AW'(push_b);
    rd_ptr_d     = rd_ptr_q + AW'(pop);
    count_d      = count_q + CW'(push_a) + CW'(push_b) - CW'(pop);
    shift_d      = shift_q;
    bytes_d      = bytes_q;
    last_d       = last_q;
    ram_wren_d   = 1'b0;
    ram_byte_d   = ram_byte_q;
    wraddr_d     = wraddr_q;
    addr_d       = addr_q;
    frame_size_d = frame_size_q;
    done_d       = done_q;
    overflow_d   = overflow_q | (bus.rdy & ~push_a) | (bus.eof_p & ~push_b);

    if (push_a) mem_d[wr_ptr_q] = '{last: 1'b0, nbits: 6'd32, word: bus.bits};
    if (push_b) mem_d[wr_ptr_q + AW'(push_a)] = '{last: 1'b1, nbits: {1'b0, bus.eof_cnt}, word: bus.bits};

    // Ones below the valid bits pad the final partial byte.
    if (pop) begin
      shift_d = head.word | (32'hFFFF_FFFF >> head.nbits);
      bytes_d = head_bytes;
      last_d  = head.last;
    end

    if (!stall) begin
      case (state_q)
        EMIT: begin
          ram_wren_d = 1'b1;
          ram_byte_d = shift_q[31:24];
          shift_d    = {shift_q[23:0], 8'hFF};
          bytes_d    = bytes_left;
        end
        STUFF: begin
          ram_wren_d = 1'b1;
          ram_byte_d = 8'h00;
        end
        EOI_FF: begin
          ram_wren_d = 1'b1;
          ram_byte_d = 8'hFF;
        end
        EOI_D9: begin
          ram_wren_d = 1'b1;
          ram_byte_d = 8'hD9;
        end
        default: ;
      endcase
    end

    if (ram_wren_d) begin
      wraddr_d = addr_q;
      addr_d   = addr_q + ADDR_W'(1);
    end

    if (state_q == DONE && state_d == IDLE) begin
      done_d = 1'b0;
      addr_d = '0;
    end

    if (state_q != DONE && state_d == DONE) begin
      done_d       = 1'b1;
      frame_size_d = addr_d;
    end
  end

  assign bus.ram_byte   = ram_byte_q;
  assign bus.ram_wren   = ram_wren_q;
  assign bus.ram_wraddr = wraddr_q;
  assign bus.frame_size = frame_size_q;
  assign bus.done       = done_q;
  assign bus.overflow   = overflow_q;
endmodule
